// File: rtl/dec_secded_serial_corrector_if.sv
// Receive-side and sink-side handshake bundle for the serial SECDED decoder,
// plus the statistics counters and their clear.
interface dec_secded_serial_corrector_if #(
   parameter int R     = 4,
   parameter int CNT_W = 16
) ();
   localparam int N      = 2 ** R;
   localparam int DATA_W = N - R - 1;

   logic              in_valid;
   logic              in_ready;
   logic [N-1:0]      codeword_with_errors;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [R:0]        out_syndrome;
   logic              out_err_single;
   logic              out_err_double;
   logic              cnt_clr;
   logic [CNT_W-1:0]  cnt_corrected;
   logic [CNT_W-1:0]  cnt_uncorrectable;

   modport master (
      output in_valid, codeword_with_errors, out_ready, cnt_clr,
      input  in_ready, out_valid, out_data, out_syndrome,
             out_err_single, out_err_double, cnt_corrected, cnt_uncorrectable
   );

   modport slave (
      input  in_valid, codeword_with_errors, out_ready, cnt_clr,
      output in_ready, out_valid, out_data, out_syndrome,
             out_err_single, out_err_double, cnt_corrected, cnt_uncorrectable
   );
endinterface

// File: rtl/dec_secded_serial_corrector.sv
// Extended-Hamming decoder: accumulates the syndrome LANES bits per cycle,
// corrects single errors, flags double errors and counts both.
module dec_secded_lane #(
   parameter int R = 4
) (
   input  logic         bit_in,
   input  logic [R-1:0] pos,
   output logic [R-1:0] term
);
   assign term = bit_in ? pos : '0;
endmodule

module dec_secded_serial_corrector #(
   parameter int R     = 4,
   parameter int LANES = 16,
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic rst,
   dec_secded_serial_corrector_if.slave bus
);
   localparam int N      = 2 ** R;
   localparam int DATA_W = N - R - 1;
   localparam int B      = N / LANES;
   localparam int BW     = (B > 1) ? $clog2(B) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                    state;
   logic [N-1:0]              cw_q;
   logic [BW-1:0]             beat;
   logic [R-1:0]              acc_idx;
   logic                      acc_par;

   logic [R-1:0]              base;
   logic [LANES-1:0]          lane_bits;
   logic [LANES-1:0][R-1:0]   term;
   logic [R-1:0]              beat_idx;
   logic                      beat_par;
   logic [R-1:0]              fin_idx;
   logic                      fin_par;
   logic                      last_beat;
   logic                      is_double;
   logic [N-1:0]              corr_cw;

   // Data bits occupy every non-power-of-two position above 0, ascending.
   function automatic logic [DATA_W-1:0] extract(input logic [N-1:0] cw);
      logic [DATA_W-1:0] d;
      int k;
      d = '0;
      k = 0;
      for (int p = 1; p < N; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[k] = cw[p];
            k++;
         end
      end
      return d;
   endfunction

   // base is a multiple of LANES, so OR-ing the lane number gives the position.
   assign base      = R'(int'(beat) * LANES);
   assign lane_bits = LANES'(cw_q >> base);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      dec_secded_lane #(.R(R)) u_lane (
         .bit_in (lane_bits[l]),
         .pos    (base | R'(l)),
         .term   (term[l])
      );
   end

   always_comb begin
      beat_idx = '0;
      for (int l = 0; l < LANES; l++) beat_idx ^= term[l];
   end

   assign beat_par  = ^lane_bits;
   assign fin_idx   = acc_idx ^ beat_idx;
   assign fin_par   = acc_par ^ beat_par;
   assign last_beat = (state == ACCUM) && (beat == BW'(B - 1));
   assign is_double = !fin_par && (fin_idx != '0);
   assign corr_cw   = fin_par ? (cw_q ^ (N'(1) << fin_idx)) : cw_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                 <= IDLE;
         cw_q                  <= '0;
         beat                  <= '0;
         acc_idx               <= '0;
         acc_par               <= 1'b0;
         bus.in_ready          <= 1'b1;
         bus.out_valid         <= 1'b0;
         bus.out_data          <= '0;
         bus.out_syndrome      <= '0;
         bus.out_err_single    <= 1'b0;
         bus.out_err_double    <= 1'b0;
         bus.cnt_corrected     <= '0;
         bus.cnt_uncorrectable <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  cw_q         <= bus.codeword_with_errors;
                  acc_idx      <= '0;
                  acc_par      <= 1'b0;
                  beat         <= '0;
                  bus.in_ready <= 1'b0;
                  state        <= ACCUM;
               end
            end
            ACCUM: begin
               acc_idx <= fin_idx;
               acc_par <= fin_par;
               beat    <= beat + BW'(1);
               if (last_beat) begin
                  bus.out_data       <= extract(corr_cw);
                  bus.out_syndrome   <= {fin_par, fin_idx};
                  bus.out_err_single <= fin_par;
                  bus.out_err_double <= is_double;
                  bus.out_valid      <= 1'b1;
                  state              <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // A clear wins over the increment of the word finishing this cycle.
         if (bus.cnt_clr) begin
            bus.cnt_corrected     <= '0;
            bus.cnt_uncorrectable <= '0;
         end else if (last_beat) begin
            if (fin_par && bus.cnt_corrected != '1)
               bus.cnt_corrected <= bus.cnt_corrected + CNT_W'(1);
            if (is_double && bus.cnt_uncorrectable != '1)
               bus.cnt_uncorrectable <= bus.cnt_uncorrectable + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_dec_secded_serial_corrector.sv
// Directed bench: full-width decoder, 4-lane serial decoder, 2-bit counters.
module tb_dec_secded_serial_corrector;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dec_secded_serial_corrector_if #(.R(4), .CNT_W(16)) if0 ();
   dec_secded_serial_corrector_if #(.R(4), .CNT_W(16)) if1 ();
   dec_secded_serial_corrector_if #(.R(4), .CNT_W(2))  if2 ();

   dec_secded_serial_corrector #(.R(4), .LANES(16), .CNT_W(16)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   dec_secded_serial_corrector #(.R(4), .LANES(4),  .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   dec_secded_serial_corrector #(.R(4), .LANES(16), .CNT_W(2))  u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send0(input logic [15:0] cw);
      if0.codeword_with_errors = cw;
      if0.in_valid = 1'b1;
      tick();
      if0.in_valid = 1'b0;
      chk("d0_busy", if0.in_ready, 0);
      tick();
   endtask

   task automatic res0(input string tag, input logic [10:0] d, input logic [4:0] s,
                       input logic sg, input logic db);
      chk({tag, "_valid"}, if0.out_valid, 1);
      chk({tag, "_data"}, if0.out_data, d);
      chk({tag, "_syn"}, if0.out_syndrome, s);
      chk({tag, "_single"}, if0.out_err_single, sg);
      chk({tag, "_double"}, if0.out_err_double, db);
      if0.out_ready = 1'b1;
      tick();
      if0.out_ready = 1'b0;
      chk({tag, "_drained"}, if0.out_valid, 0);
   endtask

   task automatic send2(input logic [15:0] cw);
      if2.codeword_with_errors = cw;
      if2.in_valid = 1'b1;
      tick();
      if2.in_valid = 1'b0;
      tick();
   endtask

   task automatic pop2();
      if2.out_ready = 1'b1;
      tick();
      if2.out_ready = 1'b0;
   endtask

   task automatic accept1(input logic [15:0] cw);
      if1.codeword_with_errors = cw;
      if1.in_valid = 1'b1;
      tick();
      if1.in_valid = 1'b0;
   endtask

   initial begin
      if0.in_valid = 0; if0.codeword_with_errors = '0; if0.out_ready = 0; if0.cnt_clr = 0;
      if1.in_valid = 0; if1.codeword_with_errors = '0; if1.out_ready = 0; if1.cnt_clr = 0;
      if2.in_valid = 0; if2.codeword_with_errors = '0; if2.out_ready = 0; if2.cnt_clr = 0;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      chk("rst_in_ready", if0.in_ready, 1);
      chk("rst_out_valid", if0.out_valid, 0);
      chk("rst_data", if0.out_data, 0);
      chk("rst_syn", if0.out_syndrome, 0);
      chk("rst_cnt_c", if0.cnt_corrected, 0);
      chk("rst_cnt_u", if0.cnt_uncorrectable, 0);
      chk("rst_in_ready1", if1.in_ready, 1);

      // Full-width decoder: one cycle from accept to result.
      send0(16'h0000); res0("zero", 11'h000, 5'h00, 0, 0);
      send0(16'h000F); res0("clean", 11'h001, 5'h00, 0, 0);
      send0(16'h040F); res0("pos10", 11'h001, 5'h1A, 1, 0);
      chk("cnt_c_1", if0.cnt_corrected, 1);
      send0(16'h140F); res0("dbl", 11'h0A1, 5'h06, 0, 1);
      chk("cnt_u_1", if0.cnt_uncorrectable, 1);
      send0(16'h000E); res0("par0", 11'h001, 5'h10, 1, 0);
      send0(16'hFFFF); res0("ones", 11'h7FF, 5'h00, 0, 0);
      send0(16'hFFF7); res0("pos3", 11'h7FF, 5'h13, 1, 0);
      chk("cnt_c_3", if0.cnt_corrected, 3);
      chk("cnt_u_1b", if0.cnt_uncorrectable, 1);

      // Two-bit counters saturate at 3.
      for (int i = 0; i < 5; i++) begin
         send2(16'h040F);
         chk("sat_cnt", if2.cnt_corrected, (i < 3) ? i + 1 : 3);
         pop2();
      end
      // Clear on the same edge as an increment.
      if2.codeword_with_errors = 16'h040F;
      if2.in_valid = 1'b1;
      tick();
      if2.in_valid = 1'b0;
      if2.cnt_clr = 1'b1;
      tick();
      if2.cnt_clr = 1'b0;
      chk("clr_cnt", if2.cnt_corrected, 0);
      chk("clr_valid", if2.out_valid, 1);
      chk("clr_single", if2.out_err_single, 1);
      pop2();
      chk("clr_cnt_u", if2.cnt_uncorrectable, 0);

      // Four-lane decoder: result after four beats, held under back-pressure.
      accept1(16'h040F);
      for (int i = 0; i < 3; i++) begin
         chk("l4_busy", if1.in_ready, 0);
         tick();
         chk("l4_early", if1.out_valid, 0);
      end
      tick();
      chk("l4_valid", if1.out_valid, 1);
      chk("l4_syn", if1.out_syndrome, 5'h1A);
      chk("l4_data", if1.out_data, 11'h001);
      if1.codeword_with_errors = 16'h000F;
      if1.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_valid", if1.out_valid, 1);
         chk("hold_syn", if1.out_syndrome, 5'h1A);
         chk("hold_data", if1.out_data, 11'h001);
         chk("hold_single", if1.out_err_single, 1);
         chk("hold_in_ready", if1.in_ready, 0);
      end
      if1.in_valid = 1'b0;
      if1.out_ready = 1'b1;
      tick();
      if1.out_ready = 1'b0;
      chk("l4_drained", if1.out_valid, 0);
      chk("l4_in_ready", if1.in_ready, 1);

      accept1(16'hFFF7);
      repeat (4) tick();
      chk("l4b_valid", if1.out_valid, 1);
      chk("l4b_syn", if1.out_syndrome, 5'h13);
      chk("l4b_data", if1.out_data, 11'h7FF);
      chk("l4b_cnt", if1.cnt_corrected, 2);
      if1.out_ready = 1'b1;
      tick();
      if1.out_ready = 1'b0;

      // Asynchronous reset in the middle of accumulation.
      accept1(16'h140F);
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", if1.in_ready, 1);
      chk("mid_rst_valid", if1.out_valid, 0);
      chk("mid_rst_cnt", if1.cnt_corrected, 0);
      chk("mid_rst_cnt0", if0.cnt_corrected, 0);
      chk("mid_rst_syn", if1.out_syndrome, 0);
      #1;
      rst = 1'b0;
      tick();
      accept1(16'h000F);
      repeat (3) tick();
      chk("post_rst_early", if1.out_valid, 0);
      tick();
      chk("post_rst_valid", if1.out_valid, 1);
      chk("post_rst_data", if1.out_data, 11'h001);
      chk("post_rst_syn", if1.out_syndrome, 5'h00);
      chk("post_rst_flags", {if1.out_err_single, if1.out_err_double}, 2'b00);
      chk("post_rst_cnt_u", if1.cnt_uncorrectable, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
